// File: rtl/hazard_unit_if.sv
// Hazard-controller bus: pipeline register addresses and control flags in,
// forwarding selects, stall/flush controls and the wait counter out.
interface hazard_unit_if #(
   parameter int REG_ADDR_W = 4,
   parameter int CNT_W      = 16
);
   logic [REG_ADDR_W-1:0] ra1_d;
   logic [REG_ADDR_W-1:0] ra2_d;
   logic [REG_ADDR_W-1:0] ra1_e;
   logic [REG_ADDR_W-1:0] ra2_e;
   logic [REG_ADDR_W-1:0] wa3_e;
   logic [REG_ADDR_W-1:0] wa3_m;
   logic [REG_ADDR_W-1:0] wa3_w;
   logic                  reg_write_m;
   logic                  reg_write_w;
   logic                  mem_to_reg_e;
   logic                  pc_src_d;
   logic                  pc_src_e;
   logic                  pc_src_p;
   logic                  branch_taken;
   logic                  mem_req_m;
   logic                  mem_ready;
   logic [1:0]            forward_a_e;
   logic [1:0]            forward_b_e;
   logic                  stall_f;
   logic                  stall_d;
   logic                  stall_e;
   logic                  stall_m;
   logic                  flush_d;
   logic                  flush_e;
   logic                  flush_w;
   logic [CNT_W-1:0]      stall_cycles;

   // Hazard unit side.
   modport slave (
      input  ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w,
             reg_write_m, reg_write_w, mem_to_reg_e,
             pc_src_d, pc_src_e, pc_src_p, branch_taken,
             mem_req_m, mem_ready,
      output forward_a_e, forward_b_e,
             stall_f, stall_d, stall_e, stall_m,
             flush_d, flush_e, flush_w, stall_cycles
   );

   // Pipeline/datapath side.
   modport master (
      output ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w,
             reg_write_m, reg_write_w, mem_to_reg_e,
             pc_src_d, pc_src_e, pc_src_p, branch_taken,
             mem_req_m, mem_ready,
      input  forward_a_e, forward_b_e,
             stall_f, stall_d, stall_e, stall_m,
             flush_d, flush_e, flush_w, stall_cycles
   );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage core: operand forwarding,
// load-use and PC-write stalls, branch flushes, and a data-memory wait FSM
// that freezes the whole pipeline while a slow access is outstanding.
module hazard_unit #(
   parameter int REG_ADDR_W = 4,
   parameter int CNT_W      = 16
) (
   input logic           clk,
   input logic           reset,
   hazard_unit_if.slave  hz
);

   localparam logic [REG_ADDR_W-1:0] PC_REG = REG_ADDR_W'(15);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_t;

   mem_state_t       state;
   logic             pcw_m;
   logic             pcw_w;
   logic [CNT_W-1:0] stall_cnt;

   logic       ldr_stall;
   logic       pc_wr_pending;
   logic       mem_wait;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   // Forwarding selects: M result wins over W; the PC is never forwarded.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (hz.reg_write_m && (hz.wa3_m == hz.ra1_e) && (hz.ra1_e != PC_REG))
         fwd_a = 2'b10;
      else if (hz.reg_write_w && (hz.wa3_w == hz.ra1_e) && (hz.ra1_e != PC_REG))
         fwd_a = 2'b01;
      if (hz.reg_write_m && (hz.wa3_m == hz.ra2_e) && (hz.ra2_e != PC_REG))
         fwd_b = 2'b10;
      else if (hz.reg_write_w && (hz.wa3_w == hz.ra2_e) && (hz.ra2_e != PC_REG))
         fwd_b = 2'b01;
   end

   assign ldr_stall     = hz.mem_to_reg_e &&
                          ((hz.wa3_e == hz.ra1_d) || (hz.wa3_e == hz.ra2_d));
   assign pc_wr_pending = hz.pc_src_d || hz.pc_src_e || pcw_m;
   assign mem_wait      = ((state == ST_IDLE) && hz.mem_req_m && !hz.mem_ready) ||
                          ((state == ST_WAIT) && !hz.mem_ready);

   // Memory wait FSM: enter WAIT on an access that is not ready, leave on ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state)
            ST_IDLE: if (hz.mem_req_m && !hz.mem_ready) state <= ST_WAIT;
            ST_WAIT: if (hz.mem_ready)                  state <= ST_IDLE;
            default:                                    state <= ST_IDLE;
         endcase
      end
   end

   // PC-write flag follows the writer through M and W; frozen during memory waits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcw_m <= 1'b0;
         pcw_w <= 1'b0;
      end else if (!mem_wait) begin
         pcw_m <= hz.pc_src_p;
         pcw_w <= pcw_m;
      end
   end

   // Saturating count of memory-wait cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (mem_wait && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // Stall/flush controls: a memory wait freezes everything and bubbles W;
   // otherwise load-use, PC-write and branch terms are OR-ed together.
   always_comb begin
      hz.stall_f = 1'b0;
      hz.stall_d = 1'b0;
      hz.stall_e = 1'b0;
      hz.stall_m = 1'b0;
      hz.flush_d = 1'b0;
      hz.flush_e = 1'b0;
      hz.flush_w = 1'b0;
      if (mem_wait) begin
         hz.stall_f = 1'b1;
         hz.stall_d = 1'b1;
         hz.stall_e = 1'b1;
         hz.stall_m = 1'b1;
         hz.flush_w = 1'b1;
      end else begin
         hz.stall_f = ldr_stall || pc_wr_pending;
         hz.stall_d = ldr_stall;
         hz.flush_d = pc_wr_pending || pcw_w || hz.branch_taken;
         hz.flush_e = ldr_stall || hz.branch_taken;
      end
   end

   assign hz.forward_a_e  = fwd_a;
   assign hz.forward_b_e  = fwd_b;
   assign hz.stall_cycles = stall_cnt;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage processor (F, D, E, M, W). It sits directly downstream of the E-stage conditional logic and consumes its condition-qualified `branch_taken` and `pc_src_p`. It produces the operand-forwarding selects and the stall/flush controls for every pipeline register. It also owns the M/W pipelining of the "PC write" flag and a data-memory wait FSM that freezes the pipeline on slow memory accesses.

## Interface
Parameters:
- `REG_ADDR_W`, 4, register-address width (register 15 = PC).
- `CNT_W`, 16, stall-cycle counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `ra1_d`, `ra2_d`  in  REG_ADDR_W  source registers of the instruction in D.
- `ra1_e`, `ra2_e`  in  REG_ADDR_W  source registers of the instruction in E.
- `wa3_e`, `wa3_m`, `wa3_w`  in  REG_ADDR_W  destination registers in E/M/W.
- `reg_write_m`, `reg_write_w`  in  1  condition-qualified register write in M/W.
- `mem_to_reg_e`  in  1  instruction in E is a load.
- `pc_src_d`, `pc_src_e`  in  1  instruction in D/E writes the PC (raw, not condition-qualified).
- `pc_src_p`  in  1  condition-qualified PC write from E.
- `branch_taken`  in  1  condition-qualified branch taken, E stage.
- `mem_req_m`  in  1  M-stage instruction accesses data memory.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `forward_a_e`, `forward_b_e`  out  2  00 = register file, 01 = W result, 10 = M ALU result.
- `stall_f`, `stall_d`, `stall_e`, `stall_m`  out  1  hold the corresponding pipeline register.
- `flush_d`, `flush_e`, `flush_w`  out  1  load a bubble into the D/E/W register.
- `stall_cycles`  out  CNT_W  saturating count of memory-wait cycles.

## Operation
Forwarding (combinational):
- `forward_a_e` = 10 if `reg_write_m` and `wa3_m == ra1_e` and `ra1_e != 15`.
- Otherwise 01 if `reg_write_w` and `wa3_w == ra1_e` and `ra1_e != 15`.
- Otherwise 00.
- M has priority over W. `forward_b_e` is computed identically using `ra2_e`.

Load-use hazard:
- `ldr_stall = mem_to_reg_e & ((wa3_e == ra1_d) | (wa3_e == ra2_d))`.

PC-write tracking:
- Registers `pcw_m` and `pcw_w` are captured as `pcw_m <= pc_src_p` and `pcw_w <= pcw_m`.
- Each register updates only when its stage is not stalled.
- `pc_wr_pending = pc_src_d | pc_src_e | pcw_m`.

Memory FSM, states IDLE and WAIT:
- IDLE to WAIT when `mem_req_m & ~mem_ready`.
- WAIT to IDLE when `mem_ready`. Otherwise remain in WAIT.
- A zero-wait access (`mem_req_m & mem_ready` in IDLE) stays in IDLE with no stall.
- `mem_wait = (state == IDLE & mem_req_m & ~mem_ready) | (state == WAIT & ~mem_ready)`.

Output equations when `mem_wait` = 1:
- `stall_f` = `stall_d` = `stall_e` = `stall_m` = 1, `flush_w` = 1.
- `flush_d` = `flush_e` = 0.
- PC-tracking registers hold.

Output equations when `mem_wait` = 0:
- `stall_f = ldr_stall | pc_wr_pending`
- `stall_d = ldr_stall`
- `stall_e` = `stall_m` = `flush_w` = 0
- `flush_d = pc_wr_pending | pcw_w | branch_taken`
- `flush_e = ldr_stall | branch_taken`

Stall counter:
- `stall_cycles` increments by 1 on every rising edge where `mem_wait` = 1.
- It saturates at all-ones and never wraps.

## Timing
- Reset values: state IDLE, `pcw_m` = `pcw_w` = 0, `stall_cycles` = 0. All other outputs are combinational from inputs and this cleared state.
- Reset asserted mid-WAIT returns the FSM to IDLE immediately, without waiting for a clock edge.
- Forwarding, stall and flush outputs are valid in the same cycle as their inputs; there are no registered outputs except `stall_cycles`.
- A `branch_taken` in cycle N gives `flush_d` = `flush_e` = 1 in cycle N; the redirect fetch occurs in N+1.
- A load-use hazard inserts exactly one E bubble: `stall_f` = `stall_d` = `flush_e` = 1 for one cycle.
- A PC write keeps `stall_f` asserted while the writer is in D, E or M. `flush_d` is also asserted in the W cycle.
- Memory wait of k cycles with `mem_ready` in cycle N+k:
  - Stalls are asserted in cycles N .. N+k-1.
  - `stall_cycles` increases by exactly k.
- A `branch_taken` held during WAIT is not lost: E is frozen, so the flush fires in the first non-wait cycle.
- When `ldr_stall`, a PC write and `branch_taken` coincide, all applicable terms are OR-ed; none of them masks another.

## Test plan
- Forwarding: `reg_write_m` = `reg_write_w` = 1, `wa3_m` = `wa3_w` = `ra1_e` = 3 gives `forward_a_e` = 10. With `ra1_e` = 15, `forward_a_e` = 00. With only `wa3_w` = 3, `forward_a_e` = 01.
- Load-use: `mem_to_reg_e` = 1, `wa3_e` = 2, `ra2_d` = 2 gives `stall_f` = `stall_d` = `flush_e` = 1 for one cycle; with `ra2_d` = 4, all are 0.
- Branch: `branch_taken` = 1 for one cycle gives `flush_d` = `flush_e` = 1 that cycle and 0 the next; `stall_f` = 0 throughout.
- PC write: pulse `pc_src_d` and follow it through E/M/W with `pc_src_p` = 1. `stall_f` = 1 for 3 cycles, and `flush_d` = 1 for 4 cycles.
- Memory wait: `mem_req_m` = 1 with `mem_ready` low for 3 cycles while `branch_taken` = 1:
  - All stalls and `flush_w` = 1 for 3 cycles, with `flush_e` = 0.
  - `flush_e` = 1 on the 4th cycle.
  - `stall_cycles` = 3.
- Reset mid-WAIT: assert `reset` asynchronously during WAIT. State becomes IDLE and `stall_cycles` becomes 0 before the next edge; with `mem_req_m` = 0 all stalls deassert.
